// File: rtl/seq_collect_pkg.sv
// seq_collect_pkg: shared types and helpers for the sample collector/replayer.
//   state_t   : controller states (IDLE -> READ -> OUTPUT -> IDLE)
//   MODE_REV  : MODE bit index selecting reverse replay order
//   MODE_MAX  : MODE bit index selecting max (1) instead of sum (0) reduction
//   clog2()   : ceil(log2(v)), used to size counters from parameters
package seq_collect_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        OUTPUT
    } state_t;

    localparam int MODE_REV = 0;
    localparam int MODE_MAX = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_reduce_acc.sv
// seq_reduce_acc: running reduction register (sum or max) over unsigned samples.
//   CLK, RST   : clock, synchronous active-high reset (clears acc)
//   ld_i       : load acc with din_i (first sample of a packet)
//   en_i       : fold din_i into acc (sum or max per max_sel_i)
//   max_sel_i  : 1 = max, 0 = sum
//   din_i      : sample, DATA_W bits
//   acc_o      : accumulated result, OUT_W bits (wide enough that sum never wraps)
module seq_reduce_acc #(
    parameter int DATA_W = 3,
    parameter int OUT_W  = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ld_i,
    input  logic              en_i,
    input  logic              max_sel_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [OUT_W-1:0]  acc_o
);

    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] din_ext;

    assign din_ext = OUT_W'(din_i);
    assign acc_o   = acc_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q <= '0;
        end else if (ld_i) begin
            acc_q <= din_ext;
        end else if (en_i) begin
            if (max_sel_i) acc_q <= (din_ext > acc_q) ? din_ext : acc_q;
            else           acc_q <= acc_q + din_ext;
        end
    end

endmodule

// File: rtl/seq_collect_replay.sv
// seq_collect_replay: captures a burst of up to DEPTH samples while IN_VALID is
// high, then replays them forward or reversed, followed by one reduction beat.
//   CLK, RST   : clock, synchronous active-high reset
//   IN_VALID   : sample strobe; a packet is a contiguous run of high cycles
//   IN_DATA    : unsigned sample
//   MODE       : bit MODE_REV = reverse replay, bit MODE_MAX = max reduction;
//                latched on the first beat of a packet
//   IN_READY   : low while replaying (input is ignored then)
//   OUT        : replayed sample (zero-extended) or reduction; 0 when idle
//   OUT_VALID  : output beat strobe, high for count+1 consecutive cycles
//   OUT_LAST   : marks the reduction beat
//   OUT_OVF    : on the reduction beat, set if any beat of the packet was dropped
module seq_collect_replay
    import seq_collect_pkg::*;
#(
    parameter  int DATA_W = 3,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = clog2(DEPTH + 1),
    localparam int OUT_W  = DATA_W + CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [1:0]        MODE,
    output logic              IN_READY,
    output logic [OUT_W-1:0]  OUT,
    output logic              OUT_VALID,
    output logic              OUT_LAST,
    output logic              OUT_OVF
);

    localparam int AW    = (DEPTH > 1) ? clog2(DEPTH) : 1;
    // Replay index runs 0..count+1 (data beats, reduction beat, exit), so it
    // needs one bit more than the stored count.
    localparam int IDX_W = CNT_W + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         mode_q, mode_d;
    logic               ovf_q, ovf_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               ov_q, ov_d;
    logic               ol_q, ol_d;
    logic               oo_q, oo_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               we;
    logic [AW-1:0]      waddr;
    logic [AW-1:0]      raddr;
    logic               acc_ld, acc_en;
    logic [OUT_W-1:0]   acc;

    seq_reduce_acc #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_acc (
        .CLK       (CLK),
        .RST       (RST),
        .ld_i      (acc_ld),
        .en_i      (acc_en),
        .max_sel_i (mode_q[MODE_MAX]),
        .din_i     (IN_DATA),
        .acc_o     (acc)
    );

    // Reverse order reads slot[count-1-i]; modular arithmetic in AW bits is
    // exact because the result is always a valid slot index.
    assign raddr = mode_q[MODE_REV] ? (AW'(cnt_q) - AW'(idx_q) - AW'(1)) : AW'(idx_q);

    assign IN_READY  = (state_q != OUTPUT);
    assign OUT       = out_q;
    assign OUT_VALID = ov_q;
    assign OUT_LAST  = ol_q;
    assign OUT_OVF   = oo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        out_d   = '0;
        ov_d    = 1'b0;
        ol_d    = 1'b0;
        oo_d    = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        acc_ld  = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    we      = 1'b1;
                    mode_d  = MODE;
                    cnt_d   = CNT_W'(1);
                    acc_ld  = 1'b1;
                    ovf_d   = 1'b0;
                    state_d = READ;
                end
            end
            READ: begin
                if (IN_VALID) begin
                    if (cnt_q < CNT_W'(DEPTH)) begin
                        we     = 1'b1;
                        waddr  = AW'(cnt_q);
                        cnt_d  = cnt_q + CNT_W'(1);
                        acc_en = 1'b1;
                    end else begin
                        ovf_d  = 1'b1;
                    end
                end else begin
                    idx_d   = '0;
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (idx_q < {1'b0, cnt_q}) begin
                    out_d = OUT_W'(mem_q[raddr]);
                    ov_d  = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                end else if (idx_q == {1'b0, cnt_q}) begin
                    out_d = acc;
                    ov_d  = 1'b1;
                    ol_d  = 1'b1;
                    oo_d  = ovf_q;
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    // Outputs fall to their zero defaults on this edge.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mode_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            oo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
            oo_q    <= oo_d;
        end
    end

    // Sample storage carries no reset; contents are only read after being written.
    always_ff @(posedge CLK) begin
        if (we && !RST) mem_q[waddr] <= IN_DATA;
    end

endmodule

// File: tb/tb_seq_collect_replay.sv
module tb_seq_collect_replay;

    localparam int DATA_W = 3;
    localparam int DEPTH  = 8;
    localparam int OUT_W  = 7;

    logic              CLK = 1'b0;
    logic              RST;
    logic              IN_VALID;
    logic [DATA_W-1:0] IN_DATA;
    logic [1:0]        MODE;
    logic              IN_READY;
    logic [OUT_W-1:0]  OUT;
    logic              OUT_VALID;
    logic              OUT_LAST;
    logic              OUT_OVF;

    seq_collect_replay #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .MODE      (MODE),
        .IN_READY  (IN_READY),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_LAST  (OUT_LAST),
        .OUT_OVF   (OUT_OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int d;
        bit last;
        bit ovf;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    stim[$];
    beat_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: keep the first DEPTH beats, replay in requested order, then
    // append sum or max of the kept beats with the drop flag.
    task automatic model(input logic [1:0] m);
        int keep[$];
        int red;
        beat_t b;
        keep.delete();
        exp_q.delete();
        for (int i = 0; i < stim.size() && i < DEPTH; i++) keep.push_back(stim[i]);
        red = 0;
        foreach (keep[i]) red = m[1] ? ((keep[i] > red) ? keep[i] : red) : red + keep[i];
        for (int i = 0; i < keep.size(); i++) begin
            b.d    = m[0] ? keep[keep.size() - 1 - i] : keep[i];
            b.last = 0;
            b.ovf  = 0;
            exp_q.push_back(b);
        end
        b.d    = red;
        b.last = 1;
        b.ovf  = (stim.size() > DEPTH);
        exp_q.push_back(b);
    endtask

    // Called at a negedge; each beat is sampled at the following posedge.
    task automatic send(input logic [1:0] m);
        foreach (stim[i]) begin
            IN_VALID = 1'b1;
            IN_DATA  = DATA_W'(stim[i]);
            MODE     = m;
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        IN_DATA  = '0;
    endtask

    task automatic collect(input bit hold);
        int  n;
        int  cyc;
        bit  done;
        @(negedge CLK);                  // E0 has passed: nothing driven yet
        chk("lat_e0_valid", OUT_VALID, 0);
        chk("lat_e0_ready", IN_READY, 0);
        if (hold) begin
            IN_VALID = 1'b1;
            IN_DATA  = 3'd4;
        end
        n = 0; cyc = 0; done = 0;
        while (!done) begin
            @(negedge CLK);
            cyc++;
            if (OUT_VALID) begin
                if (n < exp_q.size()) begin
                    chk("data", OUT, exp_q[n].d);
                    chk("last", OUT_LAST, exp_q[n].last);
                    chk("ovf", OUT_OVF, exp_q[n].ovf);
                end
                chk("ready_busy", IN_READY, 0);
                n++;
            end else begin
                chk("out_idle_zero", OUT, 0);
                done = 1;
            end
            if (!done && cyc > 40) begin
                chk("timeout", 0, 1);
                done = 1;
            end
        end
        IN_VALID = 1'b0;
        IN_DATA  = '0;
        chk("nbeats", n, exp_q.size());
        chk("ready_end", IN_READY, 1);
    endtask

    task automatic pkt(input logic [1:0] m, input bit hold);
        model(m);
        send(m);
        collect(hold);
    endtask

    initial begin
        RST      = 1'b1;
        IN_VALID = 1'b0;
        IN_DATA  = '0;
        MODE     = '0;
        repeat (3) @(negedge CLK);
        chk("rst_out", OUT, 0);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_last", OUT_LAST, 0);
        chk("rst_ovf", OUT_OVF, 0);
        chk("rst_ready", IN_READY, 1);
        RST = 1'b0;
        @(negedge CLK);

        stim = '{1, 2, 3, 4, 5};       pkt(2'd0, 0);
        stim = '{7, 0, 6};             pkt(2'd1, 0);
        stim = '{3, 7, 2};             pkt(2'd2, 0);
        stim = '{5};                   pkt(2'd3, 0);
        stim = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7}; pkt(2'd0, 0);
        stim = '{1, 1};                pkt(2'd0, 0);
        stim = '{3, 1, 6, 2};          pkt(2'd1, 1);

        // Reset pulsed after the second output beat discards the replay.
        stim = '{1, 2, 3};
        send(2'd0);
        @(negedge CLK);
        chk("rst_mid_e0", OUT_VALID, 0);
        @(negedge CLK);
        chk("rst_mid_b0", OUT, 1);
        @(negedge CLK);
        chk("rst_mid_b1", OUT, 2);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_mid_out", OUT, 0);
        chk("rst_mid_valid", OUT_VALID, 0);
        chk("rst_mid_ready", IN_READY, 1);
        @(negedge CLK);
        chk("rst_mid_quiet", OUT_VALID, 0);
        stim = '{2, 2};                pkt(2'd0, 0);

        for (int p = 0; p < 30; p++) begin
            int len;
            logic [1:0] m;
            bit h;
            len = $urandom_range(1, 11);
            m   = 2'($urandom_range(0, 3));
            h   = 1'($urandom_range(0, 1));
            stim.delete();
            for (int i = 0; i < len; i++) stim.push_back($urandom_range(0, 7));
            pkt(m, h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
